// File: rtl/word_to_bits_guard.sv
// Command word to discrete outputs with per-channel minimum hold and latched trip.
// Optional parity checking on load is enabled by defining WTB_PARITY_EN.
module word_to_bits_guard #(
  parameter int   WIDTH      = 16,
  parameter int   N_CH       = 10,
  parameter int   MIN_HOLD   = 8,
  parameter int   CNT_W      = 8,
  parameter logic SAFE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             trip,
  input  logic             trip_clr,
  output logic [N_CH-1:0]  out,
  output logic [N_CH-1:0]  pending,
  output logic             tripped,
  output logic             parity_err
);

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(MIN_HOLD);
  localparam logic [N_CH-1:0]  SAFE = {N_CH{SAFE_LEVEL}};

  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  out_q, out_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic             tripped_q, tripped_d;
  logic             load_ok;
  logic             unused_hi;

  assign unused_hi = ^data_in[WIDTH-1:N_CH];

`ifdef WTB_PARITY_EN
  logic perr_q, perr_d;
  logic par_bad;
  logic par_set;

  // Top bit carries even parity over the channel bits.
  assign par_bad = data_in[WIDTH-1] ^ (^data_in[N_CH-1:0]);
  assign par_set = load & ~tripped_q & ~trip & par_bad;
  assign load_ok = load & ~tripped_q & ~par_bad;

  always_comb begin
    perr_d = perr_q;
    if (par_set)
      perr_d = 1'b1;
    if (trip_clr)
      perr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      perr_q <= 1'b0;
    else
      perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`else
  assign load_ok    = load & ~tripped_q;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    shadow_d  = shadow_q;
    out_d     = out_q;
    tripped_d = tripped_q;
    for (int i = 0; i < N_CH; i++)
      cnt_d[i] = cnt_q[i];

    if (trip) begin
      // Trip bypasses the hold guard entirely.
      tripped_d = 1'b1;
      shadow_d  = SAFE;
      out_d     = SAFE;
      for (int i = 0; i < N_CH; i++)
        cnt_d[i] = '0;
    end else begin
      if (trip_clr)
        tripped_d = 1'b0;
      if (load_ok)
        shadow_d = data_in[N_CH-1:0];
      // Outputs follow the registered shadow, one cycle behind it.
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end else if (out_q[i] != shadow_q[i]) begin
          out_d[i] = shadow_q[i];
          cnt_d[i] = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q  <= SAFE;
      out_q     <= SAFE;
      tripped_q <= 1'b0;
      for (int i = 0; i < N_CH; i++)
        cnt_q[i] <= '0;
    end else begin
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      tripped_q <= tripped_d;
      for (int i = 0; i < N_CH; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign out     = out_q;
  assign pending = shadow_q ^ out_q;
  assign tripped = tripped_q;

endmodule

// File: tb/tb_word_to_bits_guard.sv
// Bench for word_to_bits_guard: directed table, hold/glitch sequences,
// and random traffic against a timestamp-based reference model.
module tb_word_to_bits_guard;

  localparam int MIN_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        load = 1'b0;
  logic        trip = 1'b0;
  logic        trip_clr = 1'b0;
  logic [9:0]  out;
  logic [9:0]  pending;
  logic        tripped;
  logic        parity_err;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  word_to_bits_guard dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .load(load), .trip(trip), .trip_clr(trip_clr),
    .out(out), .pending(pending), .tripped(tripped),
    .parity_err(parity_err)
  );

  typedef struct {
    logic        r;
    logic [15:0] d;
    logic        ld;
    logic        tr;
    logic        clr;
    logic [9:0]  e_out;
    logic [9:0]  e_pend;
    logic        e_trip;
  } vec_t;

  vec_t tv[20];

  // Reference state: last transition time per channel instead of counters.
  logic [9:0] m_sh, m_out;
  logic       m_trip;
  int         m_last[10];
  int         cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] d,
                      input logic ld, input logic tr, input logic clr);
    rst_n = r; data_in = d; load = ld; trip = tr; trip_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, input logic [15:0] d,
                            input logic ld, input logic tr,
                            input logic clr);
    if (!r) begin
      m_sh = '0; m_out = '0; m_trip = 1'b0;
      for (int i = 0; i < 10; i++) m_last[i] = -1000;
    end else if (tr) begin
      m_sh = '0; m_out = '0; m_trip = 1'b1;
      for (int i = 0; i < 10; i++) m_last[i] = -1000;
    end else begin
      for (int i = 0; i < 10; i++)
        if (m_out[i] != m_sh[i] && cyc - m_last[i] > MIN_HOLD) begin
          m_out[i] = m_sh[i];
          m_last[i] = cyc;
        end
      if (ld && !m_trip) m_sh = d[9:0];
      if (clr) m_trip = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    tv[0]  = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0};
    tv[1]  = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0};
    tv[2]  = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0};
    tv[3]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0};
    tv[4]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 10'h000, 10'h005, 1'b0};
    tv[5]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h005, 10'h000, 1'b0};
    tv[6]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h005, 10'h000, 1'b0};
    tv[7]  = '{1'b1, 16'h03FF, 1'b1, 1'b0, 1'b0, 10'h005, 10'h3FA, 1'b0};
    tv[8]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h000, 1'b0};
    tv[9]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 1'b1};
    tv[10] = '{1'b1, 16'h03FF, 1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 1'b1};
    tv[11] = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 10'h000, 10'h000, 1'b1};
    tv[12] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 10'h000, 10'h000, 1'b0};
    tv[13] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0};
    tv[14] = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 10'h000, 10'h003, 1'b0};
    tv[15] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h003, 10'h000, 1'b0};
    tv[16] = '{1'b1, 16'h03FF, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 1'b1};
    tv[17] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 10'h000, 10'h000, 1'b0};
    tv[18] = '{1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 1'b0};
    tv[19] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0};

    @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) begin
      step(tv[k].r, tv[k].d, tv[k].ld, tv[k].tr, tv[k].clr);
      chk($sformatf("tv%0d.out", k), 32'(out), 32'(tv[k].e_out));
      chk($sformatf("tv%0d.pend", k), 32'(pending), 32'(tv[k].e_pend));
      chk($sformatf("tv%0d.trip", k), 32'(tripped), 32'(tv[k].e_trip));
      chk($sformatf("tv%0d.perr", k), 32'(parity_err), 32'd0);
    end

    // Hold guard: rise at k+1, fall only at k+10.
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    chk("hold.k.out", 32'(out[0]), 32'd0);
    chk("hold.k.pend", 32'(pending[0]), 32'd1);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("hold.k1.out", 32'(out[0]), 32'd1);
    chk("hold.k1.pend", 32'(pending[0]), 32'd0);
    step(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("hold.k2.out", 32'(out[0]), 32'd1);
    chk("hold.k2.pend", 32'(pending[0]), 32'd1);
    for (int e = 3; e <= 9; e++) begin
      step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk($sformatf("hold.k%0d.out", e), 32'(out[0]), 32'd1);
      chk($sformatf("hold.k%0d.pend", e), 32'(pending[0]), 32'd1);
    end
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("hold.k10.out", 32'(out[0]), 32'd0);
    chk("hold.k10.pend", 32'(pending[0]), 32'd0);

    // Glitch absorb: 1 -> 0 -> 1 inside the hold window.
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("glitch.rise", 32'(out[0]), 32'd1);
    step(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e < 12; e++) begin
      step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk($sformatf("glitch.c%0d", e), 32'(out[0]), 32'd1);
    end
    chk("glitch.pend", 32'(pending), 32'd0);

    // Random traffic against the reference model.
    cyc = 0;
    model_step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      logic        r, ld, tr, clr;
      logic [15:0] d;
      r   = ($urandom_range(0, 199) != 0);
      d   = 16'($urandom);
      ld  = ($urandom_range(0, 9) < 3);
      tr  = ($urandom_range(0, 99) < 2);
      clr = ($urandom_range(0, 99) < 6);
      model_step(r, d, ld, tr, clr);
      step(r, d, ld, tr, clr);
      chk($sformatf("rnd%0d.out", n), 32'(out), 32'(m_out));
      chk($sformatf("rnd%0d.pend", n), 32'(pending), 32'(m_sh ^ m_out));
      chk($sformatf("rnd%0d.trip", n), 32'(tripped), 32'(m_trip));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/word_to_bits_guard.md
Name: word_to_bits_guard

Overview:
- Parametrised successor to the 16-bit word-to-discrete-output converter used for gate-driver and relay outputs in the vector-control datapath.
- Captures a command word on a load strobe and distributes its low N_CH bits to individual registered outputs.
- Enforces a per-channel minimum hold time between output transitions.
- Provides a latched trip path that forces every output to a safe level until explicitly cleared.

Parameters:
- WIDTH, 16, width of data_in.
- N_CH, 10, number of driven output channels; 1 <= N_CH <= WIDTH-1.
- MIN_HOLD, 8, minimum clk cycles an output must stay at a level before it may toggle again; 0 disables the guard.
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > MIN_HOLD.
- SAFE_LEVEL, 0, 1-bit level driven on all outputs while tripped and after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- data_in  in  WIDTH  command word; bit i drives channel i for i < N_CH.
- load  in  1  capture strobe; data_in is sampled in the cycle load=1.
- trip  in  1  fault request, level-sensitive.
- trip_clr  in  1  trip clear request, single-cycle pulse.
- out  out  N_CH  channel outputs.
- pending  out  N_CH  bit i = 1 when shadow[i] != out[i], i.e. a change is waiting on the hold timer.
- tripped  out  1  latched trip status.
- parity_err  out  1  sticky parity error flag; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out, shadow and pending all = {N_CH{SAFE_LEVEL}} / 0 as applicable.
  - All hold counters = 0; tripped = 0; parity_err = 0.
  - Reset has priority over every other input.
- Shadow register:
  - On a clk edge with load=1 and tripped=0, shadow <= data_in[N_CH-1:0].
  - load is ignored while tripped=1.
- Per-channel hold counter cnt[i]:
  - If out[i] != shadow[i] and cnt[i] == 0: out[i] <= shadow[i] and cnt[i] <= MIN_HOLD.
  - Otherwise, if cnt[i] != 0: cnt[i] decrements by 1 and out[i] holds.
  - Minimum spacing between two transitions on one channel is therefore MIN_HOLD+1 cycles.
  - With MIN_HOLD = 0, cnt stays 0 and out follows shadow with a one-cycle lag.
- Latency and update order:
  - Load at edge k gives out at edge k+1 when cnt = 0, i.e. out changes one cycle after shadow.
  - A shadow change that arrives mid-hold is applied at the first edge after cnt[i] reaches 0, using the value shadow holds at that time.
  - A shadow[i] that toggles and returns to out[i] within the hold window produces no output transition.
- Trip:
  - On a clk edge with trip=1: tripped <= 1, out <= SAFE_LEVEL, shadow <= SAFE_LEVEL, all cnt <= 0.
  - The hold guard is bypassed on trip entry.
  - While tripped=1, outputs stay SAFE_LEVEL.
  - trip_clr=1 with trip=0 clears tripped at the edge; trip=1 takes priority over trip_clr.
  - After a clear, outputs stay SAFE_LEVEL until the next load.
- Simultaneous events:
  - trip and load at the same edge: trip wins and the load is discarded.
  - load on two consecutive cycles: the second word overwrites shadow; only the latest value propagates.
- pending is combinational from shadow and out, so it asserts in the same cycle shadow differs from out.

Optional Feature:
- Macro WTB_PARITY_EN.
- When defined:
  - data_in[WIDTH-1] is the even-parity bit over data_in[N_CH-1:0].
  - On a load with a parity mismatch, shadow is not updated and parity_err <= 1.
  - parity_err is sticky and is cleared only by reset or by trip_clr.
- When undefined:
  - parity_err is tied 0 and all loads are accepted.
  - data_in bits at positions N_CH and above are ignored.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with data_in=16'hFFFF and load=1 -> out=10'h000, tripped=0, pending=0; release reset with load=0 -> out stays 10'h000.
- Load latency: with MIN_HOLD=8, load 16'h0005 at edge k -> shadow=10'h005 at k, out=10'h005 at k+1, pending is 1 only between k and k+1.
- Hold guard: toggle bit 0 by loading 16'h0001 at edge k, then 16'h0000 at k+2 -> out[0] rises at k+1, falls at k+10 (9 cycles after the rise), pending[0]=1 from k+2 to k+10.
- Glitch absorb: during the hold window load 16'h0000 then 16'h0001 -> out[0] shows no transition.
- Trip: with out=10'h3FF, assert trip for 1 cycle -> out=10'h000 at that edge and tripped=1; a load of 16'h03FF is ignored; trip_clr with trip=1 has no effect; trip_clr with trip=0 -> tripped=0 and out stays 0 until the next load.
- Parity (WTB_PARITY_EN): load 16'h0001 (parity bit 0, mismatch) -> shadow unchanged and parity_err=1; then load 16'h8001 -> accepted and out[0]=1 one cycle later, parity_err still 1 until trip_clr.
